// File: rtl/prog_loader_if.sv
// prog_loader host/memory bundle.
// Byte input, reload and instruction-memory write side.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              i_valid;
  logic [7:0]        i_byte;
  logic              i_reload;
  logic              o_inCmd;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [15:0]       o_wdata;
  logic              o_done;
  logic              o_ovf;
  logic [ADDR_W:0]   o_word_cnt;

  modport master (
    output i_valid, i_byte, i_reload,
    input  o_inCmd, o_we, o_waddr, o_wdata,
    input  o_done, o_ovf, o_word_cnt
  );

  modport slave (
    input  i_valid, i_byte, i_reload,
    output o_inCmd, o_we, o_waddr, o_wdata,
    output o_done, o_ovf, o_word_cnt
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: byte-serial loader into instruction memory.
// Pairs bytes hi/lo into words, writes them at an auto-incrementing address.
module prog_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [15:0] TERM   = 16'hFFFF
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);
  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [7:0]        hi, hi_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [15:0]       wdata_n;
  logic              ovf_n;
  logic [15:0]       word;

  assign word           = {hi, bus.i_byte};
  assign bus.o_word_cnt = cnt;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_HI;
      hi          <= '0;
      cnt         <= '0;
      bus.o_we    <= 1'b0;
      bus.o_waddr <= '0;
      bus.o_wdata <= '0;
      bus.o_ovf   <= 1'b0;
      bus.o_inCmd <= 1'b1;
      bus.o_done  <= 1'b0;
    end else begin
      state       <= state_n;
      hi          <= hi_n;
      cnt         <= cnt_n;
      bus.o_we    <= we_n;
      bus.o_waddr <= waddr_n;
      bus.o_wdata <= wdata_n;
      bus.o_ovf   <= ovf_n;
      bus.o_inCmd <= (state_n != DONE);
      bus.o_done  <= (state_n == DONE);
    end
  end

  // Next-state: byte pairing, write issue, full/terminator/reload.
  always_comb begin
    state_n = state;
    hi_n    = hi;
    cnt_n   = cnt;
    we_n    = 1'b0;
    waddr_n = bus.o_waddr;
    wdata_n = bus.o_wdata;
    ovf_n   = bus.o_ovf;
    unique case (state)
      LOAD_HI: begin
        if (bus.i_valid) begin
          hi_n    = bus.i_byte;
          state_n = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (bus.i_valid) begin
          if (word == TERM) begin
            state_n = DONE;
          end else begin
            we_n    = 1'b1;
            waddr_n = cnt[ADDR_W-1:0];
            wdata_n = word;
            cnt_n   = cnt + 1'b1;
            // Last slot just written: stop rather than wrap.
            if (&cnt[ADDR_W-1:0]) begin
              state_n = DONE;
              ovf_n   = 1'b1;
            end else begin
              state_n = LOAD_HI;
            end
          end
        end
      end
      DONE: begin
        if (bus.i_reload) begin
          state_n = LOAD_HI;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = LOAD_HI;
    endcase
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random + directed bench for prog_loader.
// Checks every cycle outcome against a byte-stream reference model.
module tb_prog_loader;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW)) bus();

  prog_loader #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model of the load as a byte stream
  bit          m_done;
  bit          m_have_hi;
  bit          m_ovf;
  logic [7:0]  m_hi;
  int          m_cnt;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_done    = 0;
    m_have_hi = 0;
    m_ovf     = 0;
    m_hi      = '0;
    m_cnt     = 0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit wrote);
    logic [15:0] w;
    wrote = 0;
    if (m_done) return;
    if (!m_have_hi) begin
      m_hi      = b;
      m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      w = {m_hi, b};
      if (w == 16'hFFFF) begin
        m_done = 1;
      end else begin
        wrote  = 1;
        m_addr = 32'(m_cnt);
        m_data = 32'(w);
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_done = 1;
          m_ovf  = 1;
        end
      end
    end
  endtask

  task automatic check_state();
    check("inCmd", 32'(bus.o_inCmd), 32'(!m_done));
    check("done", 32'(bus.o_done), 32'(m_done));
    check("ovf", 32'(bus.o_ovf), 32'(m_ovf));
    check("word_cnt", 32'(bus.o_word_cnt), 32'(m_cnt));
    check("waddr", 32'(bus.o_waddr), m_addr);
    check("wdata", 32'(bus.o_wdata), m_data);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit wrote;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("idle_we", 32'(bus.o_we), 32'd0);
    end
    bus.i_valid = 1'b1;
    bus.i_byte  = b;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_byte  = $urandom;
    model_byte(b, wrote);
    check("we", 32'(bus.o_we), 32'(wrote));
    check_state();
  endtask

  task automatic send_word(input logic [15:0] w, input int g_hi, input int g_lo);
    send_byte(w[15:8], g_hi);
    send_byte(w[7:0], g_lo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_we", 32'(bus.o_we), 32'd0);
    check_state();
  endtask

  task automatic reload_pulse();
    bus.i_reload = 1'b1;
    @(negedge clk);
    bus.i_reload = 1'b0;
    if (m_done) begin
      m_done    = 0;
      m_have_hi = 0;
      m_cnt     = 0;
      m_ovf     = 0;
    end
    check("reload_we", 32'(bus.o_we), 32'd0);
    check_state();
  endtask

  initial begin
    logic [15:0] w;
    int n;
    bus.i_valid  = 1'b0;
    bus.i_byte   = '0;
    bus.i_reload = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_we", 32'(bus.o_we), 32'd0);
    check_state();

    // reset mid-word discards the held high byte
    send_byte(8'hAB, 0);
    do_reset();
    send_word(16'h1234, 0, 0);
    send_word(16'hFFFF, 0, 0);

    // basic back-to-back load
    do_reset();
    send_word(16'hABCD, 0, 0);
    send_word(16'h0101, 0, 0);
    send_word(16'h2424, 0, 0);
    send_word(16'h4242, 0, 0);
    send_word(16'hFFFF, 0, 0);
    send_word(16'h7777, 1, 0);

    // near-terminator words are data
    do_reset();
    send_word(16'h00FF, 0, 0);
    send_word(16'hFF00, 0, 0);
    send_word(16'hFFFF, 0, 0);

    // gaps, plus reload mid-load is ignored
    do_reset();
    send_word(16'hABCD, 3, 5);
    send_byte(8'h01, 2);
    reload_pulse();
    send_byte(8'h01, 4);
    send_word(16'h2424, 0, 1);
    send_word(16'hFFFF, 5, 2);

    // overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(16'(i * 16'h1111 + 1), 0, 0);
    send_word(16'h3C3C, 0, 1);
    send_word(16'hFFFF, 0, 0);

    // reload from full
    reload_pulse();
    send_word(16'h5555, 0, 0);
    send_word(16'hFFFF, 0, 0);

    // randomized loads
    for (int it = 0; it < 12; it++) begin
      if (m_done && $urandom_range(0, 1) == 1) reload_pulse();
      else do_reset();
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        case ($urandom_range(0, 7))
          0: w = 16'h00FF;
          1: w = 16'hFF00;
          default: ;
        endcase
        if (w == 16'hFFFF) w = 16'h0000;
        send_byte(w[15:8], $urandom_range(0, 5));
        if ($urandom_range(0, 4) == 0) reload_pulse();
        send_byte(w[7:0], $urandom_range(0, 5));
      end
      send_word(16'hFFFF, $urandom_range(0, 2), $urandom_range(0, 2));
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
